// File: rtl/cms_axi_lite_cmd_port.sv
// AXI4-Lite write-only slave: captures AW/W, checks legality, issues one cmd per legal write, always answers on B.
// Latency: cmd_valid 1 cycle after AW+W capture, bvalid 1 cycle after cmd handshake; cmd_ready/bready stall the FSM in place.
module cms_axi_lite_cmd_port #(
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int AXI_ADDR_WIDTH   = 4,
    parameter int S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    output logic [AXI_DATA_WIDTH-1:0]     cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [7:0]                    err_count
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                        state, state_nx;
    logic                          aw_full, w_full;
    logic [S_AXI_ADDR_WIDTH-1:0]   aw_buf;
    logic [AXI_DATA_WIDTH-1:0]     w_buf;
    logic [STRB_W-1:0]             strb_buf;

    logic                          aw_cap, w_cap, aw_have, w_have;
    logic [S_AXI_ADDR_WIDTH-1:0]   addr_eff;
    logic [AXI_DATA_WIDTH-1:0]     data_eff;
    logic [STRB_W-1:0]             strb_eff;
    logic                          dec_err, slv_err;
    logic                          accept_ok, accept_err, cmd_fire, b_fire;

    // The check may happen on the very edge that captures the second channel,
    // so look through the buffers to the live bus when a buffer is still empty.
    assign aw_cap   = (state == IDLE) && s_axi_awvalid && s_axi_awready;
    assign w_cap    = (state == IDLE) && s_axi_wvalid && s_axi_wready;
    assign aw_have  = aw_full || aw_cap;
    assign w_have   = w_full || w_cap;
    assign addr_eff = aw_full ? aw_buf : s_axi_awaddr;
    assign data_eff = w_full ? w_buf : s_axi_wdata;
    assign strb_eff = w_full ? strb_buf : s_axi_wstrb;

    assign dec_err  = (addr_eff >> (AXI_ADDR_WIDTH + 2)) != '0;
    assign slv_err  = (strb_eff != '1) || (addr_eff[1:0] != 2'b00);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign b_fire   = s_axi_bvalid && s_axi_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept_ok  = 1'b0;
        accept_err = 1'b0;
        case (state)
            IDLE: begin
                if (aw_have && w_have) begin
                    if (dec_err || slv_err) begin
                        accept_err = 1'b1;
                        state_nx   = RESP;
                    end else begin
                        accept_ok  = 1'b1;
                        state_nx   = ISSUE;
                    end
                end
            end
            ISSUE:   if (cmd_fire) state_nx = RESP;
            RESP:    if (b_fire)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_buf        <= '0;
            w_buf         <= '0;
            strb_buf      <= '0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            cmd_valid     <= 1'b0;
            cmd_addr      <= '0;
            cmd_data      <= '0;
            err_count     <= 8'd0;
        end else begin
            if (aw_cap) begin
                aw_full       <= 1'b1;
                aw_buf        <= s_axi_awaddr;
                s_axi_awready <= 1'b0;
            end
            if (w_cap) begin
                w_full       <= 1'b1;
                w_buf        <= s_axi_wdata;
                strb_buf     <= s_axi_wstrb;
                s_axi_wready <= 1'b0;
            end
            if (accept_ok) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= addr_eff[AXI_ADDR_WIDTH+1:2];
                cmd_data  <= data_eff;
            end
            if (accept_err) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= dec_err ? 2'b11 : 2'b10;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (state == ISSUE && cmd_fire) begin
                cmd_valid    <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= 2'b00;
            end
            if (state == RESP && b_fire) begin
                s_axi_bvalid  <= 1'b0;
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                s_axi_awready <= 1'b1;
                s_axi_wready  <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cms_axi_lite_cmd_port.md
Name: cms_axi_lite_cmd_port

Overview:
- AXI4-Lite write-only slave front end for continuous_monitoring_system.
- Accepts host writes on the AW/W/B channels and turns each legal write into a single internal command (register index plus data), delivered with a valid/ready handshake.
- Converts the byte-addressed AXI space to the monitor's internal register index and answers every write with a B response.
- Rejects illegal writes without forwarding them, and counts them.

Parameters:
- AXI_DATA_WIDTH, 32, data width of the W channel and of cmd_data.
- AXI_ADDR_WIDTH, 4, width of the internal register index (cmd_addr); 16 registers by default.
- S_AXI_ADDR_WIDTH, 8, width of the AXI byte address; must be at least AXI_ADDR_WIDTH+2.

Ports:
- clk  input  1  system clock; all logic rises on its positive edge.
- rst_n  input  1  asynchronous active-low reset.
- s_axi_awaddr  input  S_AXI_ADDR_WIDTH  write byte address.
- s_axi_awvalid  input  1  AW valid.
- s_axi_awready  output  1  AW ready.
- s_axi_wdata  input  AXI_DATA_WIDTH  write data.
- s_axi_wstrb  input  AXI_DATA_WIDTH/8  byte strobes.
- s_axi_wvalid  input  1  W valid.
- s_axi_wready  output  1  W ready.
- s_axi_bresp  output  2  write response.
- s_axi_bvalid  output  1  B valid.
- s_axi_bready  input  1  B ready.
- cmd_addr  output  AXI_ADDR_WIDTH  internal register index.
- cmd_data  output  AXI_DATA_WIDTH  command data.
- cmd_valid  output  1  command valid.
- cmd_ready  input  1  downstream accepts the command.
- err_count  output  8  saturating count of rejected writes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, except s_axi_awready=1 and s_axi_wready=1. Both holding buffers are empty and the FSM is in IDLE.
- Reset mid-operation: any transaction in flight is dropped. No B response and no command is issued for it.
- All outputs are driven directly from registers.

FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - AW and W are captured independently into one-entry holding registers, in either order or in the same cycle.
  - s_axi_awready is high only while the AW buffer is empty; s_axi_wready only while the W buffer is empty. Each drops the cycle after its capture.
  - When both buffers are full (this may be the capture edge itself), the write is checked.
  - Legal write: move to ISSUE.
  - Illegal write: load s_axi_bresp, increment err_count, move to RESP.
- Legality checks:
  - Word index is awaddr[AXI_ADDR_WIDTH+1:2].
  - awaddr[1:0] must be 0.
  - Bits above AXI_ADDR_WIDTH+1 must be 0; otherwise bresp=DECERR (2'b11).
  - wstrb must be all ones; otherwise bresp=SLVERR (2'b10). DECERR takes priority over SLVERR.
- ISSUE:
  - cmd_valid=1; cmd_addr and cmd_data hold stable until the cycle cmd_valid&&cmd_ready.
  - On that handshake: bresp=OKAY (2'b00), move to RESP.
  - cmd_valid must never drop without a handshake.
- RESP:
  - s_axi_bvalid=1 with s_axi_bresp stable until bvalid&&bready.
  - On that handshake: clear both buffers, return to IDLE; awready and wready are high on the next cycle.
- Latency, with AW+W handshaking at edge N and cmd_ready=1, bready=1:
  - cmd_valid is high in cycle N+1.
  - bvalid is high in cycle N+2.
  - awready and wready are high again in N+3.
  - Throughput: one write per 3 cycles.
- Ordering: one transaction is outstanding at a time. A second AW arriving while W is pending is not accepted (awready stays low).
- err_count: 8-bit, saturates at 255, never wraps. Cleared only by reset.

Test Plan:
- AW(awaddr=0x0C) and W(wdata=0xDEADBEEF, wstrb=0xF) in the same cycle, cmd_ready=1, bready=1 -> cmd_valid one cycle with cmd_addr=3, cmd_data=0xDEADBEEF; then bvalid with bresp=00; awready/wready back high 3 cycles after the handshake.
- W first, AW 5 cycles later (awaddr=0x04) -> wready low after the W capture; command issued only after the AW capture with cmd_addr=1; single B response.
- cmd_ready held low 10 cycles -> cmd_valid, cmd_addr and cmd_data stable for all 10 cycles; no bvalid until cmd_ready rises; awready stays low throughout.
- awaddr=0x40 (out of range) -> no cmd_valid, bresp=11, err_count 0->1. wstrb=0x3 at a legal address -> bresp=10, err_count 1->2. Out-of-range address with partial wstrb -> bresp=11.
- 260 illegal writes -> err_count saturates at 255.
- rst_n asserted while in ISSUE and while in RESP -> cmd_valid and bvalid drop immediately (asynchronously); awready=wready=1 after release; the next legal write completes normally.
